// File: rtl/dmni_br_mon_writer_pkg.sv
// Shared types for the BrLite monitor write-back engine: packet layout and FSM encoding.
package dmni_br_mon_writer_pkg;

    localparam int BRLITE_MON_MAX_NSVC = 4;
    localparam int MSVC_W              = $clog2(BRLITE_MON_MAX_NSVC);

    typedef struct packed {
        logic [31:0]       payload;
        logic [15:0]       seq_source;
        logic [15:0]       producer;   // {x[15:8], y[7:0]}
        logic [MSVC_W-1:0] msvc;
    } brlite_mon_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITE,
        CLR_WRITE
    } mon_wr_state_t;

    function automatic logic [7:0] producer_x(input logic [15:0] producer);
        return producer[15:8];
    endfunction

    function automatic logic [7:0] producer_y(input logic [15:0] producer);
        return producer[7:0];
    endfunction

endpackage

// File: rtl/dmni_br_mon_writer_if.sv
// Packet-in and memory-write-out handshakes of the monitor writer, seen from the writer (master).
interface dmni_br_mon_writer_if
    import dmni_br_mon_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  mon_valid_i;
    logic                  mon_ready_o;
    brlite_mon_t           mon_i;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_data_o;
    logic                  mem_gnt_i;

    modport master (
        input  mon_valid_i, mon_i, mem_gnt_i,
        output mon_ready_o, mem_req_o, mem_addr_o, mem_data_o
    );

    modport slave (
        output mon_valid_i, mon_i, mem_gnt_i,
        input  mon_ready_o, mem_req_o, mem_addr_o, mem_data_o
    );

endinterface

// File: rtl/dmni_br_mon_writer_fifo.sv
// DEPTH-entry packet buffer; full/empty come straight from the registered occupancy count.
module brlite_mon_fifo
    import dmni_br_mon_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  brlite_mon_t push_data_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output brlite_mon_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;
    brlite_mon_t      mem_q [DEPTH];

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries data only, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/dmni_br_mon_writer.sv
// BrLite monitor write-back engine: buffers packets, writes payloads into per-service
// tables at ptr[msvc] + 4*(y*MC_X + x), and walks enabled tables to zero them on clear.
module dmni_br_mon_writer
    import dmni_br_mon_writer_pkg::*;
#(
    parameter  int NSVC       = 2,
    parameter  int DEPTH      = 4,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DROP_WIDTH = 16,
    localparam int SVC_W      = (NSVC > 1) ? $clog2(NSVC) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    dmni_br_mon_writer_if.master  bus,
    input  logic [7:0]            mc_x_i,
    input  logic [7:0]            mc_y_i,
    input  logic                  ptr_we_i,
    input  logic [SVC_W-1:0]      ptr_sel_i,
    input  logic [ADDR_WIDTH-1:0] ptr_i,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic [DROP_WIDTH-1:0] drop_cnt_o
);

    mon_wr_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q [NSVC];
    logic [ADDR_WIDTH-1:0] ptr_d [NSVC];
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [SVC_W-1:0]      clr_svc_q, clr_svc_d;
    logic [15:0]           clr_idx_q, clr_idx_d;
    logic                  clear_pend_q, clear_pend_d;
    logic                  restart_q, restart_d;
    logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    brlite_mon_t           head;

    logic [7:0]            head_x;
    logic [7:0]            head_y;
    logic                  head_ok;
    logic [15:0]           head_prod;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [15:0]           tot_words;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  first_found;
    logic [SVC_W-1:0]      first_svc;
    logic                  nxt_found;
    logic [SVC_W-1:0]      nxt_svc;
    logic                  unused_seq;

    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_WIDTH'(1);
    endfunction

    brlite_mon_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (bus.mon_valid_i),
        .push_data_i (bus.mon_i),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    assign unused_seq = ^head.seq_source;

    always_comb begin
        ptr_d = ptr_q;
        if (ptr_we_i && (int'(ptr_sel_i) < NSVC)) begin
            ptr_d[ptr_sel_i] = ptr_i;
        end
    end

    // Head decode: drop rules and table address for the packet at the FIFO head.
    always_comb begin
        head_x    = producer_x(head.producer);
        head_y    = producer_y(head.producer);
        head_prod = {8'd0, head_y} * {8'd0, mc_x_i};
        head_ok   = (int'(head.msvc) < NSVC)
                    && (ptr_q[head.msvc[SVC_W-1:0]] != '0)
                    && (head_x < mc_x_i)
                    && (head_y < mc_y_i);
        head_addr = ptr_q[head.msvc[SVC_W-1:0]]
                    + ((ADDR_WIDTH'(head_prod) + ADDR_WIDTH'(head_x)) << 2);
    end

    // Clear walk: enabled-service search reads the pointers live.
    always_comb begin
        tot_words   = {8'd0, mc_x_i} * {8'd0, mc_y_i};
        clr_addr    = ptr_q[clr_svc_q] + (ADDR_WIDTH'(clr_idx_q) << 2);
        first_found = 1'b0;
        first_svc   = '0;
        nxt_found   = 1'b0;
        nxt_svc     = '0;
        for (int s = 0; s < NSVC; s++) begin
            if (ptr_q[s] != '0) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_svc   = SVC_W'(s);
                end
                if (!nxt_found && (s > int'(clr_svc_q))) begin
                    nxt_found = 1'b1;
                    nxt_svc   = SVC_W'(s);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        clr_svc_d    = clr_svc_q;
        clr_idx_d    = clr_idx_q;
        clear_pend_d = clear_pend_q | clear_i;
        restart_d    = restart_q;
        drop_cnt_d   = drop_cnt_q;
        fifo_pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (clear_pend_q) begin
                    restart_d = 1'b0;
                    if (first_found && (tot_words != '0)) begin
                        state_d   = CLR_WRITE;
                        clr_svc_d = first_svc;
                        clr_idx_d = '0;
                    end else begin
                        clear_pend_d = clear_i;
                    end
                end else if (!fifo_empty) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                fifo_pop = 1'b1;
                if (head_ok) begin
                    addr_d  = head_addr;
                    data_d  = head.payload;
                    state_d = WRITE;
                end else begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                    state_d    = IDLE;
                end
            end
            WRITE: begin
                if (bus.mem_gnt_i) begin
                    state_d = IDLE;
                end
            end
            CLR_WRITE: begin
                // A new clear lets the current word finish, then restarts from IDLE.
                if (clear_i) begin
                    restart_d = 1'b1;
                end
                if (bus.mem_gnt_i) begin
                    if (restart_q || clear_i) begin
                        state_d   = IDLE;
                        restart_d = 1'b0;
                    end else if ((clr_idx_q + 16'd1) == tot_words) begin
                        if (nxt_found) begin
                            clr_svc_d = nxt_svc;
                            clr_idx_d = '0;
                        end else begin
                            state_d      = IDLE;
                            clear_pend_d = 1'b0;
                        end
                    end else begin
                        clr_idx_d = clr_idx_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            clr_svc_q    <= '0;
            clr_idx_q    <= '0;
            clear_pend_q <= 1'b0;
            restart_q    <= 1'b0;
            drop_cnt_q   <= '0;
            for (int s = 0; s < NSVC; s++) begin
                ptr_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            clr_svc_q    <= clr_svc_d;
            clr_idx_q    <= clr_idx_d;
            clear_pend_q <= clear_pend_d;
            restart_q    <= restart_d;
            drop_cnt_q   <= drop_cnt_d;
            ptr_q        <= ptr_d;
        end
    end

    // Outputs decode from registered state so reset drops mem_req_o at once.
    always_comb begin
        bus.mon_ready_o = !fifo_full;
        bus.mem_req_o   = (state_q == WRITE) || (state_q == CLR_WRITE);
        bus.mem_addr_o  = '0;
        bus.mem_data_o  = '0;
        if (state_q == WRITE) begin
            bus.mem_addr_o = addr_q;
            bus.mem_data_o = data_q;
        end else if (state_q == CLR_WRITE) begin
            bus.mem_addr_o = clr_addr;
        end
    end

    assign busy_o     = (state_q != IDLE) || !fifo_empty || clear_pend_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_dmni_br_mon_writer.sv
// Randomised bench for dmni_br_mon_writer against a queue-based model of expected memory writes.
module tb_dmni_br_mon_writer;
    import dmni_br_mon_writer_pkg::*;

    localparam int NSVC  = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 4;
    localparam int DMAX  = (1 << DW) - 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    mc_x = 8'd4;
    logic [7:0]    mc_y = 8'd4;
    logic          ptr_we = 1'b0;
    logic [0:0]    ptr_sel = 1'b0;
    logic [AW-1:0] ptr_val = '0;
    logic          clear = 1'b0;
    logic          busy;
    logic [DW-1:0] drop_cnt;
    int            gnt_mode = 0;

    int            n_checks = 0;
    int            n_errors = 0;

    logic [31:0]   m_ptr [NSVC];
    int            m_drops = 0;
    wr_t           exp_q [$];

    dmni_br_mon_writer_if #(.ADDR_WIDTH(AW)) bus ();

    dmni_br_mon_writer #(
        .NSVC       (NSVC),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .DROP_WIDTH (DW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus.master),
        .mc_x_i     (mc_x),
        .mc_y_i     (mc_y),
        .ptr_we_i   (ptr_we),
        .ptr_sel_i  (ptr_sel),
        .ptr_i      (ptr_val),
        .clear_i    (clear),
        .busy_o     (busy),
        .drop_cnt_o (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic brlite_mon_t mk_pkt(input int msvc, input int x, input int y, input logic [31:0] payload);
        brlite_mon_t p;
        p.payload    = payload;
        p.seq_source = 16'($urandom);
        p.producer   = {8'(x), 8'(y)};
        p.msvc       = MSVC_W'(msvc);
        return p;
    endfunction

    // Reference: each accepted packet either counts a drop or appends one table write.
    function automatic void model_accept(input brlite_mon_t p);
        int s = int'(p.msvc);
        int x = int'(p.producer[15:8]);
        int y = int'(p.producer[7:0]);
        if (s >= NSVC || m_ptr[s % NSVC] == 0 || x >= int'(mc_x) || y >= int'(mc_y)) begin
            m_drops++;
        end else begin
            exp_q.push_back('{addr: m_ptr[s] + 32'(4 * (y * int'(mc_x) + x)), data: p.payload});
        end
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < NSVC; s++) begin
            if (m_ptr[s] != 0) begin
                for (int i = 0; i < int'(mc_x) * int'(mc_y); i++) begin
                    exp_q.push_back('{addr: m_ptr[s] + 32'(4 * i), data: 32'd0});
                end
            end
        end
    endfunction

    function automatic int exp_drops();
        return (m_drops > DMAX) ? DMAX : m_drops;
    endfunction

    initial begin
        bus.mem_gnt_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                0:       bus.mem_gnt_i = 1'b0;
                1:       bus.mem_gnt_i = 1'b1;
                default: bus.mem_gnt_i = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Observe handshakes half a cycle before the edge that completes them.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (bus.mon_valid_i && bus.mon_ready_o) begin
                model_accept(bus.mon_i);
            end
            if (bus.mem_req_o && bus.mem_gnt_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("write_expected", {63'd0, bus.mem_req_o}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wr_addr", 64'(bus.mem_addr_o), 64'(e.addr));
                    check_eq("wr_data", 64'(bus.mem_data_o), 64'(e.data));
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_drops = 0;
        for (int s = 0; s < NSVC; s++) m_ptr[s] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_ptr(input int sel, input logic [31:0] val);
        ptr_we  = 1'b1;
        ptr_sel = 1'(sel);
        ptr_val = val;
        @(posedge clk);
        #1;
        ptr_we = 1'b0;
        m_ptr[sel] = val;
    endtask

    task automatic send(input brlite_mon_t p);
        bus.mon_valid_i = 1'b1;
        bus.mon_i       = p;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.mon_ready_o) begin
                @(posedge clk);
                #1;
                bus.mon_valid_i = 1'b0;
                return;
            end
        end
        bus.mon_valid_i = 1'b0;
        check_eq("send_timeout", {63'd0, bus.mon_ready_o}, 64'd1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic wait_req(output int cycles);
        cycles = 0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (bus.mem_req_o) return;
        end
        check_eq("req_timeout", {63'd0, bus.mem_req_o}, 64'd1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq("idle", {63'd0, busy}, 64'd0);
        check_eq("pending_writes", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        bus.mon_valid_i = 1'b0;
        bus.mon_i       = '0;

        // Reset values
        do_reset();
        @(negedge clk);
        check_eq("rst_req", {63'd0, bus.mem_req_o}, 64'd0);
        check_eq("rst_addr", 64'(bus.mem_addr_o), 64'd0);
        check_eq("rst_data", 64'(bus.mem_data_o), 64'd0);
        check_eq("rst_drop", 64'(drop_cnt), 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_ready", {63'd0, bus.mon_ready_o}, 64'd1);
        @(posedge clk);
        #1;

        // Single write, latency and hold under gnt low
        mc_x = 8'd4;
        mc_y = 8'd4;
        gnt_mode = 0;
        set_ptr(0, 32'h1000);
        send(mk_pkt(0, 2, 1, 32'hCAFE));
        wait_req(cyc);
        check_eq("t1_latency", 64'(cyc), 64'd2);
        check_eq("t1_addr", 64'(bus.mem_addr_o), 64'h1018);
        repeat (3) begin
            @(negedge clk);
            check_eq("t1_hold_req", {63'd0, bus.mem_req_o}, 64'd1);
            check_eq("t1_hold_addr", 64'(bus.mem_addr_o), 64'h1018);
            check_eq("t1_hold_data", 64'(bus.mem_data_o), 64'hCAFE);
        end
        gnt_mode = 1;
        wait_idle();

        // Drops: disabled service, then x out of range
        send(mk_pkt(1, 0, 0, 32'h1111));
        wait_idle();
        check_eq("t2_drop1", 64'(drop_cnt), 64'(exp_drops()));
        check_eq("t2_drop1_abs", 64'(drop_cnt), 64'd1);
        send(mk_pkt(0, 4, 0, 32'h2222));
        wait_idle();
        check_eq("t2_drop2", 64'(drop_cnt), 64'd2);

        // Back-pressure: 5 accepted while the memory stalls
        gnt_mode = 0;
        for (int i = 0; i < 5; i++) send(mk_pkt(0, i % 4, i / 4, 32'hA0 + 32'(i)));
        repeat (2) begin
            @(negedge clk);
            check_eq("t3_ready_low", {63'd0, bus.mon_ready_o}, 64'd0);
        end
        @(posedge clk);
        #1;
        check_eq("t3_queued", 64'(exp_q.size()), 64'd5);
        repeat (40) @(posedge clk);
        #1;
        gnt_mode = 1;
        send(mk_pkt(0, 3, 3, 32'hA5));
        wait_idle();

        // Table clear of two services
        mc_x = 8'd2;
        mc_y = 8'd2;
        set_ptr(0, 32'h2000);
        set_ptr(1, 32'h3000);
        gnt_mode = 2;
        pulse_clear();
        wait_idle();
        check_eq("t4_busy", {63'd0, busy}, 64'd0);

        // Clear arriving mid-WRITE, packets arriving during the clear
        gnt_mode = 0;
        send(mk_pkt(1, 1, 1, 32'hBEEF));
        wait_req(cyc);
        @(posedge clk);
        #1;
        pulse_clear();
        gnt_mode = 2;
        send(mk_pkt(0, 1, 0, 32'h5A5A));
        send(mk_pkt(1, 0, 1, 32'hA5A5));
        wait_idle();

        // Randomised traffic
        do_reset();
        mc_x = 8'($urandom_range(1, 6));
        mc_y = 8'($urandom_range(1, 6));
        set_ptr(0, {$urandom_range(1, 32'hFFFF), 4'h0});
        set_ptr(1, ($urandom_range(0, 1) != 0) ? {$urandom_range(1, 32'hFFFF), 4'h0} : 32'd0);
        gnt_mode = 2;
        for (int i = 0; i < 60; i++) begin
            send(mk_pkt($urandom_range(0, 3), $urandom_range(0, int'(mc_x)),
                        $urandom_range(0, int'(mc_y)), $urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();
        check_eq("rand_drops", 64'(drop_cnt), 64'(exp_drops()));
        pulse_clear();
        wait_idle();

        // Asynchronous reset mid-WRITE
        gnt_mode = 0;
        set_ptr(0, 32'h4000);
        send(mk_pkt(0, 0, 0, 32'h7777));
        wait_req(cyc);
        rst_n = 1'b0;
        #1;
        check_eq("t6_req_async", {63'd0, bus.mem_req_o}, 64'd0);
        exp_q.delete();
        m_drops = 0;
        for (int s = 0; s < NSVC; s++) m_ptr[s] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t6_ready", {63'd0, bus.mon_ready_o}, 64'd1);
        check_eq("t6_drop", 64'(drop_cnt), 64'd0);
        check_eq("t6_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;

        // Pointers are cleared by reset, so every packet drops and the count saturates
        gnt_mode = 1;
        for (int i = 0; i < DMAX + 5; i++) send(mk_pkt(0, 0, 0, $urandom));
        wait_idle();
        check_eq("t6_sat_model", 64'(drop_cnt), 64'(exp_drops()));
        check_eq("t6_sat", 64'(drop_cnt), 64'(DMAX));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
